intr_timer_ctrl: RTL and testbench

Machine-level interrupt source and arbitration block that feeds the CSR array. It holds a 64-bit free-running counter (FRC) with a compare register and synchronizes the external interrupt line. It arbitrates the two sources against the mie/mstatus enables and issues a single-cycle take pulse aligned to the CPU PC stage. It also drives the raw pending levels the CSR array uses for mip and mcause.

---
 rtl/intr_timer_ctrl_if.sv | 30 +++
 rtl/intr_timer_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_intr_timer_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intr_timer_ctrl_if.sv
// intr_timer_ctrl_if
//   Register bus between a CPU-side master and intr_timer_ctrl.
//   io_we     write strobe
//   io_re     read strobe
//   io_adr    register select: 0 FRC_LO, 1 FRC_HI, 2 CMP_LO, 3 CMP_HI, 4 CTRL
//   io_wdata  write data
//   io_rdata  registered read data, returned by the slave
interface intr_timer_ctrl_if;
  logic        io_we;
  logic        io_re;
  logic [2:0]  io_adr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (
    output io_we,
    output io_re,
    output io_adr,
    output io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_we,
    input  io_re,
    input  io_adr,
    input  io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/intr_timer_ctrl.sv
// intr_timer_ctrl
//   Machine-level interrupt source and arbitration for the CSR array.
//   Holds a 64-bit free-running counter (FRC) with a 64-bit compare register,
//   synchronizes the external interrupt line, and issues a single-cycle take
//   pulse aligned to the CPU PC-update stage.
//
//   Build option: INTR_EXT_SYNC_EN
//     defined   - ext_irq_in passes a 2-flop synchronizer (2-cycle latency)
//     undefined - single register stage, synchronous sources only (1 cycle)
//
//   Parameter PRESCALE (1..255): FRC advances once every PRESCALE clk cycles.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     ext_irq_in              external interrupt request (level)
//     csr_rmie                mstatus.MIE
//     csr_meie, csr_mtie      mie.MEIE, mie.MTIE
//     cpu_stat_pc             CPU PC-update stage, one pulse per instruction
//     cmd_mret_ex             mret executing, one-cycle pulse
//     io                      register bus (slave modport)
//     g_interrupt             synchronized external level, unmasked
//     frc_cntr_val_leq        CTRL.EN & (CMP <= FRC), unmasked
//     interrupts_in_pc_state  take pulse to the CSR array
//     g_interrupt_priv        constant M-mode (2'b11)
module intr_timer_ctrl #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ext_irq_in,
  input  logic                     csr_rmie,
  input  logic                     csr_meie,
  input  logic                     csr_mtie,
  input  logic                     cpu_stat_pc,
  input  logic                     cmd_mret_ex,
  intr_timer_ctrl_if.slave         io,
  output logic                     g_interrupt,
  output logic                     frc_cntr_val_leq,
  output logic                     interrupts_in_pc_state,
  output logic [1:0]               g_interrupt_priv
);

  localparam logic [2:0] ADR_FRC_LO = 3'd0;
  localparam logic [2:0] ADR_FRC_HI = 3'd1;
  localparam logic [2:0] ADR_CMP_LO = 3'd2;
  localparam logic [2:0] ADR_CMP_HI = 3'd3;
  localparam logic [2:0] ADR_CTRL   = 3'd4;

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_TAKEN = 2'd2;

  logic [63:0] frc;
  logic [63:0] cmp;
  logic [7:0]  presc;
  logic        ctrl_en;
  logic        frc_tick;

  logic wr_frc_lo, wr_frc_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_ctrl_clr;

  logic       ext_pend, tmr_pend, irq_cond;
  logic [1:0] state, state_nxt;

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  assign wr_frc_lo   = io.io_we && (io.io_adr == ADR_FRC_LO);
  assign wr_frc_hi   = io.io_we && (io.io_adr == ADR_FRC_HI);
  assign wr_cmp_lo   = io.io_we && (io.io_adr == ADR_CMP_LO);
  assign wr_cmp_hi   = io.io_we && (io.io_adr == ADR_CMP_HI);
  assign wr_ctrl     = io.io_we && (io.io_adr == ADR_CTRL);
  assign wr_ctrl_clr = wr_ctrl && io.io_wdata[1];

  assign frc_tick = ctrl_en && (presc == PRESC_LAST);

  // ---------------------------------------------------------------------------
  // FRC and prescaler. Software writes take precedence over the increment and
  // restart the prescale period so the new value holds for a full period.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frc   <= '0;
      presc <= '0;
    end else if (wr_ctrl_clr) begin
      frc   <= '0;
      presc <= '0;
    end else if (wr_frc_lo) begin
      frc[31:0] <= io.io_wdata;
      presc     <= '0;
    end else if (wr_frc_hi) begin
      frc[63:32] <= io.io_wdata;
      presc      <= '0;
    end else if (ctrl_en) begin
      if (frc_tick) begin
        frc   <= frc + 64'd1;
        presc <= '0;
      end else begin
        presc <= presc + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp <= '1;
    end else if (wr_cmp_lo) begin
      cmp[31:0] <= io.io_wdata;
    end else if (wr_cmp_hi) begin
      cmp[63:32] <= io.io_wdata;
    end
  end

  // CLR (bit1) is a pulse only; it is never stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en <= io.io_wdata[0];
    end
  end

  // Each half reads the live register; no cross-half snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.io_rdata <= '0;
    end else if (io.io_re) begin
      case (io.io_adr)
        ADR_FRC_LO: io.io_rdata <= frc[31:0];
        ADR_FRC_HI: io.io_rdata <= frc[63:32];
        ADR_CMP_LO: io.io_rdata <= cmp[31:0];
        ADR_CMP_HI: io.io_rdata <= cmp[63:32];
        ADR_CTRL:   io.io_rdata <= {31'd0, ctrl_en};
        default:    io.io_rdata <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // External interrupt synchronization
  // ---------------------------------------------------------------------------
`ifdef INTR_EXT_SYNC_EN
  logic ext_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_meta    <= 1'b0;
      g_interrupt <= 1'b0;
    end else begin
      ext_meta    <= ext_irq_in;
      g_interrupt <= ext_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_interrupt <= 1'b0;
    end else begin
      g_interrupt <= ext_irq_in;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign frc_cntr_val_leq = ctrl_en && (cmp <= frc);

  // External outranks timer for mcause; both feed the same take condition.
  assign ext_pend = g_interrupt && csr_meie;
  assign tmr_pend = frc_cntr_val_leq && csr_mtie;
  assign irq_cond = (ext_pend || tmr_pend) && csr_rmie;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (irq_cond) state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (!irq_cond)       state_nxt = ST_IDLE;
        else if (cpu_stat_pc) state_nxt = ST_TAKEN;
      end
      ST_TAKEN: begin
        if (cmd_mret_ex) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign interrupts_in_pc_state = (state == ST_PEND) && cpu_stat_pc && irq_cond;
  assign g_interrupt_priv       = 2'b11;

endmodule

// File: tb/tb_intr_timer_ctrl.sv
// tb_intr_timer_ctrl
//   Self-checking bench for intr_timer_ctrl. Two instances share all inputs:
//   dut1 with PRESCALE=1 and dut4 with PRESCALE=4. Inputs change 1 time unit
//   after the rising edge; outputs are sampled on the falling edge.
module tb_intr_timer_ctrl;

  localparam logic [2:0] A_FRC_LO = 3'd0;
  localparam logic [2:0] A_FRC_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO = 3'd2;
  localparam logic [2:0] A_CMP_HI = 3'd3;
  localparam logic [2:0] A_CTRL   = 3'd4;

`ifdef INTR_EXT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ext_irq_in, csr_rmie, csr_meie, csr_mtie, cpu_stat_pc, cmd_mret_ex;
  logic io_we, io_re;
  logic [2:0]  io_adr;
  logic [31:0] io_wdata;

  logic       g1, leq1, pulse1, g4, leq4, pulse4;
  logic [1:0] priv1, priv4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  intr_timer_ctrl_if bus1 ();
  intr_timer_ctrl_if bus4 ();

  assign bus1.io_we    = io_we;
  assign bus1.io_re    = io_re;
  assign bus1.io_adr   = io_adr;
  assign bus1.io_wdata = io_wdata;
  assign bus4.io_we    = io_we;
  assign bus4.io_re    = io_re;
  assign bus4.io_adr   = io_adr;
  assign bus4.io_wdata = io_wdata;

  intr_timer_ctrl #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ext_irq_in(ext_irq_in), .csr_rmie(csr_rmie),
    .csr_meie(csr_meie), .csr_mtie(csr_mtie), .cpu_stat_pc(cpu_stat_pc),
    .cmd_mret_ex(cmd_mret_ex), .io(bus1.slave), .g_interrupt(g1),
    .frc_cntr_val_leq(leq1), .interrupts_in_pc_state(pulse1),
    .g_interrupt_priv(priv1)
  );

  intr_timer_ctrl #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ext_irq_in(ext_irq_in), .csr_rmie(csr_rmie),
    .csr_meie(csr_meie), .csr_mtie(csr_mtie), .cpu_stat_pc(cpu_stat_pc),
    .cmd_mret_ex(cmd_mret_ex), .io(bus4.slave), .g_interrupt(g4),
    .frc_cntr_val_leq(leq4), .interrupts_in_pc_state(pulse4),
    .g_interrupt_priv(priv4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    io_we = 1'b1; io_adr = a; io_wdata = d;
    cyc();
    io_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d1, output logic [31:0] d4);
    io_re = 1'b1; io_adr = a;
    cyc();
    io_re = 1'b0;
    d1 = bus1.io_rdata;
    d4 = bus4.io_rdata;
  endtask

  task automatic apply_reset();
    ext_irq_in = 0; csr_rmie = 0; csr_meie = 0; csr_mtie = 0;
    cpu_stat_pc = 0; cmd_mret_ex = 0;
    io_we = 0; io_re = 0; io_adr = '0; io_wdata = '0;
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    logic [31:0] r1, r4;
    apply_reset();
    @(negedge clk);
    n_checks++; if (pulse1 !== 1'b0) $display("FAIL rst_pulse: got %b expected 0", pulse1); else n_pass++;
    n_checks++; if (g1 !== 1'b0) $display("FAIL rst_g: got %b expected 0", g1); else n_pass++;
    n_checks++; if (leq1 !== 1'b0) $display("FAIL rst_leq: got %b expected 0", leq1); else n_pass++;
    n_checks++; if (bus1.io_rdata !== 32'd0) $display("FAIL rst_rdata: got %h expected 0", bus1.io_rdata); else n_pass++;
    n_checks++; if (priv1 !== 2'b11) $display("FAIL rst_priv: got %b expected 11", priv1); else n_pass++;
    cyc();
    bus_read(A_CMP_LO, r1, r4);
    n_checks++; if (r1 !== 32'hFFFF_FFFF) $display("FAIL rst_cmp_lo: got %h expected ffffffff", r1); else n_pass++;
    bus_read(A_CMP_HI, r1, r4);
    n_checks++; if (r1 !== 32'hFFFF_FFFF) $display("FAIL rst_cmp_hi: got %h expected ffffffff", r1); else n_pass++;
    bus_read(3'd5, r1, r4);
    n_checks++; if (r1 !== 32'd0) $display("FAIL undef_adr: got %h expected 0", r1); else n_pass++;
    bus_read(A_FRC_LO, r1, r4);
    n_checks++; if (r1 !== 32'd0) $display("FAIL rst_frc_lo: got %h expected 0", r1); else n_pass++;
  endtask

  task automatic test_regs();
    logic [31:0] v [4];
    logic [31:0] r1, r4;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      v[i] = $urandom;
      bus_write(3'(i), v[i]);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(3'(i), r1, r4);
      n_checks++; if (r1 !== v[i]) $display("FAIL regs_rb%0d: got %h expected %h", i, r1, v[i]); else n_pass++;
    end
    bus_write(A_CTRL, 32'h3);
    bus_read(A_CTRL, r1, r4);
    n_checks++; if (r1 !== 32'h1) $display("FAIL ctrl_rb: got %h expected 1", r1); else n_pass++;
  endtask

  task automatic test_sync_latency();
    apply_reset();
    ext_irq_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (g1 !== (k >= SYNC_LAT)) $display("FAIL sync_lat_k%0d: got %b expected %b", k, g1, (k >= SYNC_LAT)); else n_pass++;
      cyc();
    end
    ext_irq_in = 1'b0;
  endtask

  // Leaves dut1 in the taken state with the timer still matching.
  task automatic test_timer_take();
    int first_leq, first_pulse, n_pulse, second_pulse, n_after;
    apply_reset();
    bus_write(A_CMP_LO, 32'd20);
    bus_write(A_CMP_HI, 32'd0);
    csr_mtie = 1'b1; csr_rmie = 1'b1;
    bus_write(A_CTRL, 32'h1);
    first_leq = -1; first_pulse = -1; n_pulse = 0;
    for (int k = 0; k < 60; k++) begin
      cpu_stat_pc = (k % 4 == 0);
      @(negedge clk);
      if (leq1 && first_leq < 0) first_leq = k;
      if (pulse1) begin n_pulse++; if (first_pulse < 0) first_pulse = k; end
      cyc();
    end
    n_checks++; if (first_leq !== 20) $display("FAIL tmr_leq_rise: got %0d expected 20", first_leq); else n_pass++;
    n_checks++; if (first_pulse !== 24) $display("FAIL tmr_pulse_cycle: got %0d expected 24", first_pulse); else n_pass++;
    n_checks++; if (n_pulse !== 1) $display("FAIL tmr_pulse_count: got %0d expected 1", n_pulse); else n_pass++;
    second_pulse = -1; n_after = 0;
    for (int k = 60; k < 80; k++) begin
      cpu_stat_pc = (k % 4 == 0);
      cmd_mret_ex = (k == 60);
      @(negedge clk);
      if (pulse1) begin n_after++; if (second_pulse < 0) second_pulse = k; end
      cyc();
    end
    cpu_stat_pc = 1'b0; cmd_mret_ex = 1'b0;
    n_checks++; if (second_pulse !== 64) $display("FAIL tmr_retake_cycle: got %0d expected 64", second_pulse); else n_pass++;
    n_checks++; if (n_after !== 1) $display("FAIL tmr_retake_count: got %0d expected 1", n_after); else n_pass++;
  endtask

  task automatic test_reset_in_taken();
    logic [31:0] r1, r4;
    bus_read(A_CMP_LO, r1, r4);
    n_checks++; if (r1 !== 32'd20) $display("FAIL taken_cmp_rb: got %h expected 14", r1); else n_pass++;
    ext_irq_in = 1'b1; csr_meie = 1'b1;
    for (int k = 0; k <= SYNC_LAT; k++) cyc();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (pulse1 !== 1'b0) $display("FAIL arst_pulse: got %b expected 0", pulse1); else n_pass++;
    n_checks++; if (g1 !== 1'b0) $display("FAIL arst_g: got %b expected 0", g1); else n_pass++;
    n_checks++; if (leq1 !== 1'b0) $display("FAIL arst_leq: got %b expected 0", leq1); else n_pass++;
    n_checks++; if (bus1.io_rdata !== 32'd0) $display("FAIL arst_rdata: got %h expected 0", bus1.io_rdata); else n_pass++;
    n_checks++; if (priv1 !== 2'b11) $display("FAIL arst_priv: got %b expected 11", priv1); else n_pass++;
    cyc();
    rst_n = 1'b1; ext_irq_in = 1'b0; csr_meie = 1'b0;
    cyc();
    bus_read(A_CMP_HI, r1, r4);
    n_checks++; if (r1 !== 32'hFFFF_FFFF) $display("FAIL arst_cmp_hi: got %h expected ffffffff", r1); else n_pass++;
  endtask

  task automatic test_reset_drops_pulse();
    apply_reset();
    csr_meie = 1'b1; csr_rmie = 1'b1; ext_irq_in = 1'b1;
    for (int k = 0; k <= SYNC_LAT; k++) cyc();
    cpu_stat_pc = 1'b1;
    #2;
    n_checks++; if (pulse1 !== 1'b1) $display("FAIL pend_pulse: got %b expected 1", pulse1); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pulse1 !== 1'b0) $display("FAIL arst_drop_pulse: got %b expected 0", pulse1); else n_pass++;
    cyc();
    rst_n = 1'b1; cpu_stat_pc = 1'b0; ext_irq_in = 1'b0;
    cyc();
  endtask

  task automatic test_ext_priority();
    int n_pulse, at;
    logic g_at;
    apply_reset();
    bus_write(A_CMP_LO, 32'd0);
    bus_write(A_CMP_HI, 32'd0);
    csr_meie = 1'b1; csr_mtie = 1'b1; ext_irq_in = 1'b1;
    bus_write(A_CTRL, 32'h1);
    for (int k = 0; k < 4; k++) cyc();
    csr_rmie = 1'b1;
    n_pulse = 0; at = -1; g_at = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cpu_stat_pc = (k == 0 || k == 3 || k == 7);
      @(negedge clk);
      if (pulse1) begin n_pulse++; if (at < 0) begin at = k; g_at = g1; end end
      cyc();
    end
    cpu_stat_pc = 1'b0; ext_irq_in = 1'b0;
    n_checks++; if (at !== 3) $display("FAIL prio_pulse_cycle: got %0d expected 3", at); else n_pass++;
    n_checks++; if (n_pulse !== 1) $display("FAIL prio_pulse_count: got %0d expected 1", n_pulse); else n_pass++;
    n_checks++; if (g_at !== 1'b1) $display("FAIL prio_g_at_pulse: got %b expected 1", g_at); else n_pass++;
  endtask

  task automatic test_masking();
    int n_pulse, at;
    apply_reset();
    csr_meie = 1'b1; ext_irq_in = 1'b1;
    n_pulse = 0;
    for (int k = 0; k < 50; k++) begin
      cpu_stat_pc = (k % 4 == 0);
      @(negedge clk);
      if (pulse1) n_pulse++;
      cyc();
    end
    n_checks++; if (n_pulse !== 0) $display("FAIL mask_no_pulse: got %0d expected 0", n_pulse); else n_pass++;
    n_checks++; if (g1 !== 1'b1) $display("FAIL mask_g: got %b expected 1", g1); else n_pass++;
    csr_rmie = 1'b1;
    n_pulse = 0; at = -1;
    for (int k = 0; k < 12; k++) begin
      cpu_stat_pc = (k % 4 == 2);
      @(negedge clk);
      if (pulse1) begin n_pulse++; if (at < 0) at = k; end
      cyc();
    end
    cpu_stat_pc = 1'b0; ext_irq_in = 1'b0;
    n_checks++; if (at !== 2) $display("FAIL unmask_pulse_cycle: got %0d expected 2", at); else n_pass++;
    n_checks++; if (n_pulse !== 1) $display("FAIL unmask_pulse_count: got %0d expected 1", n_pulse); else n_pass++;
  endtask

  task automatic test_withdraw();
    int n_pulse;
    apply_reset();
    csr_meie = 1'b1; csr_rmie = 1'b1; ext_irq_in = 1'b1;
    for (int k = 0; k <= SYNC_LAT; k++) cyc();
    ext_irq_in = 1'b0;
    n_pulse = 0;
    for (int k = 0; k < 20; k++) begin
      cpu_stat_pc = (k > SYNC_LAT) && (k % 2 == 0);
      @(negedge clk);
      if (pulse1) n_pulse++;
      cyc();
    end
    cpu_stat_pc = 1'b0;
    n_checks++; if (n_pulse !== 0) $display("FAIL withdraw_no_pulse: got %0d expected 0", n_pulse); else n_pass++;
    n_checks++; if (g1 !== 1'b0) $display("FAIL withdraw_g: got %b expected 0", g1); else n_pass++;
  endtask

  task automatic test_prescale_wrap();
    logic [63:0] start, frc_m;
    logic [31:0] r1, r4;
    logic        leq_m;
    apply_reset();
    start = 64'hFFFF_FFFF_FFFF_FFFE;
    bus_write(A_FRC_HI, 32'hFFFF_FFFF);
    bus_write(A_FRC_LO, 32'hFFFF_FFFE);
    bus_write(A_CTRL, 32'h1);
    for (int k = 0; k < 12; k++) begin
      frc_m = start + 64'(k / 4);
      leq_m = (frc_m >= 64'hFFFF_FFFF_FFFF_FFFF);
      io_re = 1'b1; io_adr = A_FRC_LO;
      @(negedge clk);
      n_checks++; if (leq4 !== leq_m) $display("FAIL ps_leq_k%0d: got %b expected %b", k, leq4, leq_m); else n_pass++;
      cyc();
      n_checks++; if (bus4.io_rdata !== frc_m[31:0]) $display("FAIL ps_frc_lo_k%0d: got %h expected %h", k, bus4.io_rdata, frc_m[31:0]); else n_pass++;
    end
    io_re = 1'b0;
    frc_m = start + 64'd3;
    bus_read(A_FRC_HI, r1, r4);
    n_checks++; if (r4 !== frc_m[63:32]) $display("FAIL ps_frc_hi: got %h expected %h", r4, frc_m[63:32]); else n_pass++;
    bus_write(A_CTRL, 32'h3);
    bus_read(A_FRC_LO, r1, r4);
    n_checks++; if (r4 !== 32'd0) $display("FAIL clr_frc_lo: got %h expected 0", r4); else n_pass++;
    bus_read(A_FRC_HI, r1, r4);
    n_checks++; if (r4 !== 32'd0) $display("FAIL clr_frc_hi: got %h expected 0", r4); else n_pass++;
    bus_read(A_CTRL, r1, r4);
    n_checks++; if (r4 !== 32'h1) $display("FAIL clr_ctrl: got %h expected 1", r4); else n_pass++;
  endtask

  // Reference: g is ext delayed by the sync latency; leq is FRC>=CMP with FRC
  // advancing once per cycle; a take happens when the request held in the
  // previous cycle, the previous cycle neither took nor was locked, and the
  // request still holds on a PC-stage cycle. A take locks until an mret.
  task automatic test_random();
    logic [63:0] frc_m, cmp_m;
    logic e1, e2, g_exp, leq_exp, cond, pend, taken, pulse_exp;
    logic cond_p, pulse_p, taken_p, mret_p;
    apply_reset();
    frc_m = {1'b0, 31'($urandom), 32'($urandom)};
    cmp_m = frc_m + 64'd150;
    bus_write(A_FRC_LO, frc_m[31:0]);
    bus_write(A_FRC_HI, frc_m[63:32]);
    bus_write(A_CMP_LO, cmp_m[31:0]);
    bus_write(A_CMP_HI, cmp_m[63:32]);
    bus_write(A_CTRL, 32'h1);
    e1 = 0; e2 = 0; cond_p = 0; pulse_p = 0; taken_p = 0; mret_p = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(5) == 0) ext_irq_in = ~ext_irq_in;
      csr_rmie = ($urandom_range(7) != 0);
      if ($urandom_range(9) == 0) csr_meie = 1'($urandom);
      if ($urandom_range(9) == 0) csr_mtie = 1'($urandom);
      cpu_stat_pc = ($urandom_range(2) == 0);
      cmd_mret_ex = ($urandom_range(11) == 0);
      @(negedge clk);
      g_exp     = (SYNC_LAT == 2) ? e2 : e1;
      leq_exp   = (frc_m >= cmp_m);
      cond      = ((g_exp && csr_meie) || (leq_exp && csr_mtie)) && csr_rmie;
      taken     = pulse_p || (taken_p && !mret_p);
      pend      = cond_p && !taken_p && !pulse_p;
      pulse_exp = pend && cpu_stat_pc && cond;
      n_checks++; if (g1 !== g_exp) $display("FAIL rnd_g_k%0d: got %b expected %b", k, g1, g_exp); else n_pass++;
      n_checks++; if (leq1 !== leq_exp) $display("FAIL rnd_leq_k%0d: got %b expected %b", k, leq1, leq_exp); else n_pass++;
      n_checks++; if (pulse1 !== pulse_exp) $display("FAIL rnd_pulse_k%0d: got %b expected %b", k, pulse1, pulse_exp); else n_pass++;
      cond_p = cond; pulse_p = pulse_exp; taken_p = taken; mret_p = cmd_mret_ex;
      e2 = e1; e1 = ext_irq_in;
      frc_m = frc_m + 64'd1;
      cyc();
    end
    cpu_stat_pc = 1'b0; cmd_mret_ex = 1'b0; ext_irq_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_regs();
    test_sync_latency();
    test_timer_take();
    test_reset_in_taken();
    test_reset_drops_pulse();
    test_ext_priority();
    test_masking();
    test_withdraw();
    test_prescale_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
